flash_wave_loader: RTL and testbench

//  SPI initiator that reads a waveform table from the external SPI flash (standard 0x03 READ)
//  and writes it byte-by-byte into the function generator's sample RAM write port.

---
 rtl/flash_wave_loader.sv | 231 +++++++++++++++++++++++
 tb/tb_flash_wave_loader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_wave_loader.sv
// flash_wave_loader: SPI mode-0 initiator that streams a table out of serial flash (READ opcode)
// and writes each received byte into the sample RAM, addressing from 0 in read order.
`default_nettype none

module flash_wave_loader #(
  parameter int          ADDR_W   = 9,
  parameter int          CLK_DIV  = 2,
  parameter logic [7:0]  READ_CMD = 8'h03
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [23:0]       flash_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              flash_csb,
  output logic              flash_clk,
  output logic              flash_io0,
  input  logic              flash_io1,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_CMD   = 3'd2,
    S_ADDR  = 3'd3,
    S_DATA  = 3'd4,
    S_TAIL  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [4:0]        bit_q, bit_d;
  logic [30:0]       tx_q, tx_d;
  logic [7:0]        rx_q, rx_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic              wr_pend_q, wr_pend_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              csb_q, csb_d;
  logic              sclk_q, sclk_d;
  logic              io0_q, io0_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;

  logic              last_cnt;
  logic [ADDR_W:0]   next_idx;

  assign last_cnt = (cnt_q == CW'(CLK_DIV - 1));
  assign next_idx = {1'b0, addr_q} + (ADDR_W+1)'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    len_d     = len_q;
    rem_d     = rem_q;
    wr_pend_d = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    csb_d     = csb_q;
    sclk_d    = sclk_q;
    io0_d     = io0_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;

    if (wr_pend_q) begin
      we_d   = 1'b1;
      data_d = rx_q;
    end
    // Hold the address on the final byte so a full-size table never wraps back to 0.
    if (we_q && (next_idx != len_q)) begin
      addr_d = addr_q + ADDR_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          if (length != '0) begin
            state_d = S_SETUP;
            busy_d  = 1'b1;
            csb_d   = 1'b0;
            io0_d   = READ_CMD[7];
            tx_d    = {READ_CMD[6:0], flash_addr};
            len_d   = length;
            rem_d   = length;
            bit_d   = '0;
            addr_d  = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      S_SETUP: begin
        if (last_cnt) begin
          cnt_d   = '0;
          state_d = S_CMD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_CMD, S_ADDR, S_DATA: begin
        if (!last_cnt) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[6:0], flash_io1};
            if ((state_q == S_DATA) && (bit_q == 5'd7)) begin
              wr_pend_d = 1'b1;
            end
          end else begin
            // Falling edge: present the next bit; zeros shift in, so MOSI idles low in DATA.
            sclk_d = 1'b0;
            io0_d  = tx_q[30];
            tx_d   = {tx_q[29:0], 1'b0};
            bit_d  = bit_q + 5'd1;
            case (state_q)
              S_CMD: begin
                if (bit_q == 5'd7) begin
                  state_d = S_ADDR;
                  bit_d   = '0;
                end
              end
              S_ADDR: begin
                if (bit_q == 5'd23) begin
                  state_d = S_DATA;
                  bit_d   = '0;
                end
              end
              default: begin
                if (bit_q == 5'd7) begin
                  bit_d = '0;
                  rem_d = rem_q - (ADDR_W+1)'(1);
                  if (rem_q == (ADDR_W+1)'(1)) begin
                    state_d = S_TAIL;
                  end
                end
              end
            endcase
          end
        end
      end

      S_TAIL: begin
        if (last_cnt) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          csb_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        csb_d   = 1'b1;
        sclk_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      len_q     <= '0;
      rem_q     <= '0;
      wr_pend_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      csb_q     <= 1'b1;
      sclk_q    <= 1'b0;
      io0_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      len_q     <= len_d;
      rem_q     <= rem_d;
      wr_pend_q <= wr_pend_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      csb_q     <= csb_d;
      sclk_q    <= sclk_d;
      io0_q     <= io0_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign flash_csb = csb_q;
  assign flash_clk = sclk_q;
  assign flash_io0 = io0_q;
  assign ram_we    = we_q;
  assign ram_addr  = addr_q;
  assign ram_data  = data_q;

endmodule

`default_nettype wire

// File: tb/tb_flash_wave_loader.sv
// Directed bench for flash_wave_loader: instance A (CLK_DIV=2) and instance B (CLK_DIV=1),
// each wired to a small behavioural SPI flash that answers the READ command.
`default_nettype none

module tb_flash_wave_loader;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          startA = 1'b0, startB = 1'b0;
  logic [23:0]   faddr = '0;
  logic [AW:0]   len = '0;

  logic          busyA, doneA, csbA, fclkA, io0A, weA;
  logic          io1A = 1'b0;
  logic [AW-1:0] raA;
  logic [7:0]    rdA;
  logic          busyB, doneB, csbB, fclkB, io0B, weB;
  logic          io1B = 1'b0;
  logic [AW-1:0] raB;
  logic [7:0]    rdB;

  int vectors = 0;
  int fails   = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  flash_wave_loader #(.ADDR_W(AW), .CLK_DIV(2), .READ_CMD(8'h03)) dutA (
    .clk(clk), .reset(reset), .start(startA), .flash_addr(faddr), .length(len),
    .busy(busyA), .done(doneA), .flash_csb(csbA), .flash_clk(fclkA), .flash_io0(io0A),
    .flash_io1(io1A), .ram_we(weA), .ram_addr(raA), .ram_data(rdA));

  flash_wave_loader #(.ADDR_W(AW), .CLK_DIV(1), .READ_CMD(8'h03)) dutB (
    .clk(clk), .reset(reset), .start(startB), .flash_addr(faddr), .length(len),
    .busy(busyB), .done(doneB), .flash_csb(csbB), .flash_clk(fclkB), .flash_io0(io0B),
    .flash_io1(io1B), .ram_we(weB), .ram_addr(raB), .ram_data(rdB));

  function automatic logic [7:0] byte_at(input logic [23:0] a);
    case (a)
      24'h100000: return 8'hAA;
      24'h100001: return 8'h55;
      24'h100002: return 8'h01;
      24'h100003: return 8'hFF;
      default:    return a[7:0] ^ 8'hC3;
    endcase
  endfunction

  // Flash model A: captures opcode+address, then shifts table bytes out on falling edges.
  int          capA = 0;
  logic [31:0] srA = '0;
  logic [7:0]  bA;
  always @(posedge fclkA or posedge csbA) begin
    if (csbA) capA = 0;
    else begin
      if (capA < 32) srA = {srA[30:0], io0A};
      capA++;
    end
  end
  always @(negedge fclkA) begin
    if (!csbA && capA >= 32) begin
      bA   = byte_at(srA[23:0] + 24'((capA - 32) / 8));
      io1A = bA[3'(7 - ((capA - 32) % 8))];
    end
  end

  int          capB = 0;
  logic [31:0] srB = '0;
  logic [7:0]  bB;
  always @(posedge fclkB or posedge csbB) begin
    if (csbB) capB = 0;
    else begin
      if (capB < 32) srB = {srB[30:0], io0B};
      capB++;
    end
  end
  always @(negedge fclkB) begin
    if (!csbB && capB >= 32) begin
      bB   = byte_at(srB[23:0] + 24'((capB - 32) / 8));
      io1B = bB[3'(7 - ((capB - 32) % 8))];
    end
  end

  logic [AW-1:0] waA[$], waB[$];
  logic [7:0]    wdA[$], wdB[$];
  int doneA_n = 0, busyA_n = 0, csbhiA_n = 0, csbtogA_n = 0, fclktogA_n = 0;
  int riseA_idx = 0, r1A = 0, r2A = 0;
  int doneB_n = 0, busyB_n = 0;
  logic fclkA_p = 1'b0, csbA_p = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (weA) begin waA.push_back(raA); wdA.push_back(rdA); end
    if (weB) begin waB.push_back(raB); wdB.push_back(rdB); end
    if (doneA) doneA_n++;
    if (doneB) doneB_n++;
    if (busyA) busyA_n++;
    if (busyB) busyB_n++;
    if (busyA && csbA) csbhiA_n++;
    if (csbA !== csbA_p) csbtogA_n++;
    if (fclkA !== fclkA_p) fclktogA_n++;
    if (!csbA && csbA_p) riseA_idx = 0;
    if (fclkA && !fclkA_p) begin
      riseA_idx++;
      if (riseA_idx == 1) r1A = cyc;
      else if (riseA_idx == 2) r2A = cyc;
    end
    fclkA_p = fclkA;
    csbA_p  = csbA;
  end

  task automatic pulse_startA(input logic [23:0] a, input logic [AW:0] l);
    @(posedge clk); #1;
    faddr = a; len = l; startA = 1'b1;
    @(posedge clk); #1;
    startA = 1'b0;
  endtask

  task automatic wait_doneA(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (doneA) begin ok = 1'b1; break; end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (busyA !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busyA); end
    vectors++; if (doneA !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", doneA); end
    vectors++; if (csbA !== 1'b1) begin fails++; $display("FAIL reset_csb got %b want 1", csbA); end
    vectors++; if (fclkA !== 1'b0) begin fails++; $display("FAIL reset_fclk got %b want 0", fclkA); end
    vectors++; if (io0A !== 1'b0) begin fails++; $display("FAIL reset_io0 got %b want 0", io0A); end
    vectors++; if (weA !== 1'b0) begin fails++; $display("FAIL reset_we got %b want 0", weA); end
    vectors++; if (raA !== '0) begin fails++; $display("FAIL reset_addr got %0d want 0", raA); end
    vectors++; if (rdA !== 8'h00) begin fails++; $display("FAIL reset_data got %h want 00", rdA); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stream;
    int b0, h0, d;
    bit ok;
    b0 = busyA_n; h0 = csbhiA_n;
    pulse_startA(24'h100000, 10'd4);
    wait_doneA(1000, ok);
    vectors++; if (!ok) begin fails++; $display("FAIL stream_done_timeout got 0 want 1"); end
    vectors++; if (srA !== 32'h03100000) begin fails++; $display("FAIL stream_cmd_addr got %h want 03100000", srA); end
    vectors++; if (r2A - r1A != 4) begin fails++; $display("FAIL stream_sclk_period got %0d want 4", r2A - r1A); end
    d = busyA_n - b0;
    vectors++; if (d < 259 || d > 261) begin fails++; $display("FAIL stream_busy_len got %0d want 260", d); end
    vectors++; if (csbhiA_n != h0) begin fails++; $display("FAIL stream_csb_low got %0d high cycles want 0", csbhiA_n - h0); end
  endtask

  task automatic check_four_writes(input int q0, input string tag);
    logic [7:0] expd [4] = '{8'hAA, 8'h55, 8'h01, 8'hFF};
    vectors++;
    if (waA.size() - q0 != 4) begin fails++; $display("FAIL %s_write_count got %0d want 4", tag, waA.size() - q0); end
    else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (waA[q0+i] !== AW'(i) || wdA[q0+i] !== expd[i]) begin
          fails++;
          $display("FAIL %s_write%0d got (%0d,%h) want (%0d,%h)", tag, i, waA[q0+i], wdA[q0+i], i, expd[i]);
        end
      end
    end
  endtask

  task automatic test_data;
    int q0, d0;
    bit ok;
    q0 = waA.size(); d0 = doneA_n;
    pulse_startA(24'h100000, 10'd4);
    wait_doneA(1000, ok);
    vectors++; if (!ok) begin fails++; $display("FAIL data_done_timeout got 0 want 1"); end
    check_four_writes(q0, "data");
    vectors++; if (doneA_n - d0 != 1) begin fails++; $display("FAIL data_done_pulses got %0d want 1", doneA_n - d0); end
    vectors++; if (csbA !== 1'b1) begin fails++; $display("FAIL data_csb_after got %b want 1", csbA); end
  endtask

  task automatic test_zero_len;
    int t0, f0, d0;
    t0 = csbtogA_n; f0 = fclktogA_n; d0 = doneA_n;
    pulse_startA(24'h100000, 10'd0);
    vectors++; if (doneA !== 1'b1) begin fails++; $display("FAIL zero_done got %b want 1", doneA); end
    vectors++; if (busyA !== 1'b0) begin fails++; $display("FAIL zero_busy got %b want 0", busyA); end
    @(posedge clk); #1;
    vectors++; if (doneA !== 1'b0) begin fails++; $display("FAIL zero_done_width got %b want 0", doneA); end
    repeat (10) @(negedge clk);
    vectors++; if (csbtogA_n != t0) begin fails++; $display("FAIL zero_csb_toggles got %0d want 0", csbtogA_n - t0); end
    vectors++; if (fclktogA_n != f0) begin fails++; $display("FAIL zero_fclk_toggles got %0d want 0", fclktogA_n - f0); end
    vectors++; if (doneA_n - d0 != 1) begin fails++; $display("FAIL zero_done_pulses got %0d want 1", doneA_n - d0); end
  endtask

  task automatic test_ignore_start;
    int q0, d0;
    bit ok;
    q0 = waA.size(); d0 = doneA_n;
    pulse_startA(24'h100000, 10'd4);
    repeat (60) @(posedge clk);
    #1; faddr = 24'h200000; len = 10'd2; startA = 1'b1;
    @(posedge clk); #1; startA = 1'b0;
    wait_doneA(1000, ok);
    vectors++; if (!ok) begin fails++; $display("FAIL ignore_done_timeout got 0 want 1"); end
    vectors++; if (srA !== 32'h03100000) begin fails++; $display("FAIL ignore_cmd_addr got %h want 03100000", srA); end
    check_four_writes(q0, "ignore");
    repeat (300) @(negedge clk);
    vectors++; if (doneA_n - d0 != 1) begin fails++; $display("FAIL ignore_done_pulses got %0d want 1", doneA_n - d0); end
    vectors++; if (busyA !== 1'b0) begin fails++; $display("FAIL ignore_busy_after got %b want 0", busyA); end
  endtask

  task automatic test_reset_mid;
    int q0, n;
    bit ok;
    bit got2;
    q0 = waA.size();
    got2 = 1'b0;
    pulse_startA(24'h100000, 10'd4);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (waA.size() >= q0 + 2) begin got2 = 1'b1; break; end
    end
    vectors++; if (!got2) begin fails++; $display("FAIL rstmid_two_bytes got %0d want 2", waA.size() - q0); end
    #2 reset = 1'b1;
    #1;
    vectors++; if (csbA !== 1'b1) begin fails++; $display("FAIL rstmid_csb got %b want 1", csbA); end
    vectors++; if (fclkA !== 1'b0) begin fails++; $display("FAIL rstmid_fclk got %b want 0", fclkA); end
    vectors++; if (busyA !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b want 0", busyA); end
    @(negedge clk); reset = 1'b0;
    n = waA.size();
    repeat (300) @(negedge clk);
    vectors++; if (waA.size() != n || n - q0 != 2) begin fails++; $display("FAIL rstmid_no_more_we got %0d want 2", waA.size() - q0); end
    q0 = waA.size();
    pulse_startA(24'h100000, 10'd4);
    wait_doneA(1000, ok);
    vectors++; if (!ok) begin fails++; $display("FAIL rstmid_restart_timeout got 0 want 1"); end
    check_four_writes(q0, "rstmid");
  endtask

  task automatic test_full_table;
    int q0, d0, b0, errs, d;
    bit ok;
    q0 = waB.size(); d0 = doneB_n; b0 = busyB_n; errs = 0; ok = 1'b0;
    @(posedge clk); #1;
    faddr = 24'h000000; len = 10'd512; startB = 1'b1;
    @(posedge clk); #1; startB = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (doneB) begin ok = 1'b1; break; end
    end
    repeat (5) @(negedge clk);
    vectors++; if (!ok) begin fails++; $display("FAIL full_done_timeout got 0 want 1"); end
    vectors++; if (waB.size() - q0 != 512) begin fails++; $display("FAIL full_write_count got %0d want 512", waB.size() - q0); end
    else begin
      for (int i = 0; i < 512; i++)
        if (waB[q0+i] !== AW'(i) || wdB[q0+i] !== (8'(i) ^ 8'hC3)) errs++;
      vectors++; if (errs != 0) begin fails++; $display("FAIL full_write_content got %0d bad writes want 0", errs); end
      vectors++; if (waB[q0+511] !== 9'd511) begin fails++; $display("FAIL full_last_addr got %0d want 511", waB[q0+511]); end
    end
    vectors++; if (raB !== 9'd511) begin fails++; $display("FAIL full_addr_no_wrap got %0d want 511", raB); end
    vectors++; if (doneB_n - d0 != 1) begin fails++; $display("FAIL full_done_pulses got %0d want 1", doneB_n - d0); end
    d = busyB_n - b0;
    vectors++; if (d < 8257 || d > 8259) begin fails++; $display("FAIL full_busy_len got %0d want 8258", d); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_data();
    test_zero_len();
    test_ignore_start();
    test_reset_mid();
    test_full_table();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

`default_nettype wire
